// File: rtl/fifo_flags.sv
// Single-clock FIFO with count-decoded status flags, a registered read port
// and a sticky overflow/underflow error flag.
module fifo_flags #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_THR  = 6,
    parameter int AEMPTY_THR = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_valid_out,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_afull,
    output logic                  o_aempty,
    output logic                  o_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   C_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   C_AFULL  = (ADDR_WIDTH + 1)'(AFULL_THR);
    localparam logic [ADDR_WIDTH:0]   C_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_THR);
    localparam logic [ADDR_WIDTH:0]   C_ZERO   = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0]   C_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR1   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;

    logic w_empty;
    logic w_full;
    logic w_wr;
    logic w_rd;
    logic w_err_set;

    // Flags decode from the registered count only.
    assign w_empty  = (r_count == C_ZERO);
    assign w_full   = (r_count == C_DEPTH);
    assign o_empty  = w_empty;
    assign o_full   = w_full;
    assign o_afull  = (r_count >= C_AFULL);
    assign o_aempty = (r_count <= C_AEMPTY);

    assign o_count     = r_count;
    assign o_data_out  = r_data_out;
    assign o_valid_out = r_valid_out;
    assign o_error     = r_error;

    // Qualify requests: a push on a full FIFO still lands when a pop frees the slot.
    always_comb begin
        w_wr      = 1'b0;
        w_rd      = 1'b0;
        w_err_set = 1'b0;
        if (i_push && (!w_full || i_pop)) begin
            w_wr = 1'b1;
        end else begin
            w_wr = 1'b0;
        end
        if (i_pop && !w_empty) begin
            w_rd = 1'b1;
        end else begin
            w_rd = 1'b0;
        end
        if ((i_push && w_full && !i_pop) || (i_pop && w_empty)) begin
            w_err_set = 1'b1;
        end else begin
            w_err_set = 1'b0;
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    // Pointers, occupancy count and sticky error.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PTR1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + C_PTR1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    // Registered read port; data_out holds its last value when nothing is read.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd;
            if (w_rd) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

endmodule
